// File: rtl/sprite_engine.sv
`default_nettype none
// ============================================================================
// Module      : sprite_engine
// Description : Draw-pixels command parser. Unpacks palette-index data bytes
//               into clipped single-pixel frame-buffer write requests.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_engine #(
    parameter logic [7:0] OPCODE         = 8'h12,
    parameter int         DISPLAY_WIDTH  = 640,
    parameter int         DISPLAY_HEIGHT = 400,
    parameter int         FIFO_DEPTH     = 2
) (
    input  logic        spi_clock_in,
    input  logic        spi_reset_in,
    input  logic [7:0]  op_code_in,
    input  logic        op_code_valid_in,
    input  logic [7:0]  operand_in,
    input  logic        operand_valid_in,
    output logic [9:0]  pixel_x_out,
    output logic [8:0]  pixel_y_out,
    output logic [3:0]  pixel_color_out,
    output logic        pixel_valid_out,
    input  logic        pixel_ready_in,
    output logic        busy_out,
    output logic        error_out
);

    localparam int              c_PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W:0] c_PTR_ONE = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W+1:0] c_OCC_FULL = (c_PTR_W + 2)'(FIFO_DEPTH);
    localparam logic [10:0]     c_DW       = 11'(DISPLAY_WIDTH);
    localparam logic [9:0]      c_DH       = 10'(DISPLAY_HEIGHT);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_HEADER = 2'd1;
    localparam logic [1:0] c_ST_DATA   = 2'd2;
    localparam logic [1:0] c_ST_DRAIN  = 2'd3;

    logic [1:0]        r_state;
    logic              r_opv_d;
    logic              r_byte_d;
    logic [3:0]        r_hdr_cnt;
    logic [9:0]        r_x0;
    logic [8:0]        r_y0;
    logic [15:0]       r_width;
    logic [7:0]        r_colors;
    logic [3:0]        r_offset;
    logic [2:0]        r_bpp;
    logic              r_flush;
    logic              r_error;
    logic [c_PTR_W:0]  r_wr_ptr;
    logic [c_PTR_W:0]  r_rd_ptr;
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [7:0]        r_sh;
    logic [3:0]        r_sh_cnt;
    logic [10:0]       r_cur_x;
    logic [9:0]        r_cur_y;
    logic [15:0]       r_col_cnt;
    logic              r_pix_valid;
    logic [9:0]        r_pix_x;
    logic [8:0]        r_pix_y;
    logic [3:0]        r_pix_color;

    logic              w_cmd;
    logic              w_start;
    logic              w_byte;
    logic              w_hdr_byte;
    logic [3:0]        w_hdr_idx;
    logic [c_PTR_W:0]  w_fifo_cnt;
    logic              w_fifo_empty;
    logic [7:0]        w_fifo_head;
    logic [c_PTR_W+1:0] w_occ;
    logic              w_occ_dec;
    logic              w_out_adv;
    logic              w_emit;
    logic              w_sh_free;
    logic              w_pop;
    logic              w_push_req;
    logic              w_push;
    logic              w_overflow;
    logic [3:0]        w_ppb;
    logic [3:0]        w_index;
    logic [3:0]        w_color;
    logic              w_on_screen;
    logic              w_row_end;

    assign w_cmd        = op_code_valid_in && (op_code_in == OPCODE);
    assign w_start      = w_cmd && !r_opv_d;
    assign w_byte       = w_cmd && operand_valid_in && !r_byte_d;
    assign w_hdr_byte   = w_byte && ((r_state == c_ST_HEADER) || ((r_state == c_ST_IDLE) && w_start));
    assign w_hdr_idx    = (r_state == c_ST_IDLE) ? 4'd0 : r_hdr_cnt;

    assign w_fifo_cnt   = r_wr_ptr - r_rd_ptr;
    assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
    assign w_fifo_head  = r_mem[r_rd_ptr[c_PTR_W-1:0]];

    // The byte being unpacked still counts against FIFO capacity until its
    // last pixel leaves the shifter.
    assign w_out_adv    = !r_pix_valid || pixel_ready_in;
    assign w_emit       = (r_sh_cnt != 4'd0) && w_out_adv;
    assign w_sh_free    = (r_sh_cnt == 4'd0) || ((r_sh_cnt == 4'd1) && w_out_adv);
    assign w_pop        = w_sh_free && !w_fifo_empty &&
                          ((r_state == c_ST_DATA) || ((r_state == c_ST_DRAIN) && !r_flush));
    assign w_occ        = {1'b0, w_fifo_cnt} + {{(c_PTR_W + 1){1'b0}}, (r_sh_cnt != 4'd0)};
    assign w_occ_dec    = ((r_sh_cnt == 4'd1) && w_out_adv) || (w_pop && (r_width == 16'd0));
    assign w_push_req   = w_byte && (r_state == c_ST_DATA);
    assign w_push       = w_push_req && ((w_occ < c_OCC_FULL) || w_occ_dec);
    assign w_overflow   = w_push_req && !w_push;

    always_comb begin
        w_ppb   = 4'd2;
        w_index = r_sh[7:4];
        case (r_bpp)
            3'd1: begin
                w_ppb   = 4'd8;
                w_index = {3'b000, r_sh[7]};
            end
            3'd2: begin
                w_ppb   = 4'd4;
                w_index = {2'b00, r_sh[7:6]};
            end
            default: begin
                w_ppb   = 4'd2;
                w_index = r_sh[7:4];
            end
        endcase
    end

    assign w_color     = w_index + r_offset;
    assign w_on_screen = (r_cur_x < c_DW) && (r_cur_y < c_DH);
    assign w_row_end   = ((r_col_cnt + 16'd1) == r_width);

    always_ff @(posedge spi_clock_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= operand_in;
        end
    end

    always_ff @(posedge spi_clock_in) begin
        if (spi_reset_in) begin
            r_state     <= c_ST_IDLE;
            r_opv_d     <= 1'b0;
            r_byte_d    <= 1'b0;
            r_hdr_cnt   <= 4'd0;
            r_x0        <= 10'd0;
            r_y0        <= 9'd0;
            r_width     <= 16'd0;
            r_colors    <= 8'd0;
            r_offset    <= 4'd0;
            r_bpp       <= 3'd0;
            r_flush     <= 1'b0;
            r_error     <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_sh        <= 8'd0;
            r_sh_cnt    <= 4'd0;
            r_cur_x     <= 11'd0;
            r_cur_y     <= 10'd0;
            r_col_cnt   <= 16'd0;
            r_pix_valid <= 1'b0;
            r_pix_x     <= 10'd0;
            r_pix_y     <= 9'd0;
            r_pix_color <= 4'd0;
        end else begin
            r_opv_d  <= op_code_valid_in;
            r_byte_d <= operand_valid_in;

            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            if (w_overflow) r_error <= 1'b1;

            // A zero-width sprite swallows data bytes without emitting pixels.
            if (w_pop) begin
                r_sh     <= w_fifo_head;
                r_sh_cnt <= (r_width == 16'd0) ? 4'd0 : w_ppb;
            end else if (w_emit) begin
                r_sh     <= r_sh << r_bpp;
                r_sh_cnt <= r_sh_cnt - 4'd1;
            end

            if (w_out_adv) begin
                r_pix_valid <= w_emit && w_on_screen;
                if (w_emit) begin
                    r_pix_x     <= r_cur_x[9:0];
                    r_pix_y     <= r_cur_y[8:0];
                    r_pix_color <= w_color;
                    if (w_row_end) begin
                        r_col_cnt <= 16'd0;
                        r_cur_x   <= {1'b0, r_x0};
                        r_cur_y   <= r_cur_y + 10'd1;
                    end else begin
                        r_col_cnt <= r_col_cnt + 16'd1;
                        r_cur_x   <= r_cur_x + 11'd1;
                    end
                end
            end

            if (w_hdr_byte && (w_hdr_idx != 4'd8)) begin
                r_hdr_cnt <= w_hdr_idx + 4'd1;
                case (w_hdr_idx)
                    4'd0: r_x0[9:8]      <= operand_in[1:0];
                    4'd1: r_x0[7:0]      <= operand_in;
                    4'd2: r_y0[8]        <= operand_in[0];
                    4'd3: r_y0[7:0]      <= operand_in;
                    4'd4: r_width[15:8]  <= operand_in;
                    4'd5: r_width[7:0]   <= operand_in;
                    4'd6: r_colors       <= operand_in;
                    default: r_offset    <= operand_in[3:0];
                endcase
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (!w_hdr_byte) r_hdr_cnt <= 4'd0;
                    if (w_start) begin
                        r_state <= c_ST_HEADER;
                        r_error <= 1'b0;
                    end
                end
                c_ST_HEADER: begin
                    if (!op_code_valid_in) begin
                        r_state <= c_ST_DRAIN;
                    end else if (w_hdr_byte && (r_hdr_cnt == 4'd7)) begin
                        r_cur_x   <= {1'b0, r_x0};
                        r_cur_y   <= {1'b0, r_y0};
                        r_col_cnt <= 16'd0;
                        if ((r_colors == 8'd2) || (r_colors == 8'd4) || (r_colors == 8'd16)) begin
                            r_bpp   <= (r_colors == 8'd2) ? 3'd1 : (r_colors == 8'd4) ? 3'd2 : 3'd4;
                            r_state <= c_ST_DATA;
                        end else begin
                            r_error <= 1'b1;
                            r_flush <= 1'b1;
                            r_state <= c_ST_DRAIN;
                        end
                    end
                end
                c_ST_DATA: begin
                    if (!op_code_valid_in) r_state <= c_ST_DRAIN;
                end
                default: begin
                    // Error drain holds until the command ends so trailing bytes are discarded.
                    if (r_flush) begin
                        r_wr_ptr <= '0;
                        r_rd_ptr <= '0;
                        if (!op_code_valid_in) begin
                            r_flush <= 1'b0;
                            r_state <= c_ST_IDLE;
                        end
                    end else if (w_fifo_empty && (r_sh_cnt == 4'd0) && !r_pix_valid) begin
                        r_state <= c_ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign pixel_x_out     = r_pix_x;
    assign pixel_y_out     = r_pix_y;
    assign pixel_color_out = r_pix_color;
    assign pixel_valid_out = r_pix_valid;
    assign error_out       = r_error;
    assign busy_out        = (r_state != c_ST_IDLE) || !w_fifo_empty ||
                             (r_sh_cnt != 4'd0) || r_pix_valid;

endmodule
`default_nettype wire
